fp_divider: RTL and testbench

- Multi-cycle IEEE-754 single-precision divider, result = dataa / datab.
- Attaches to the Nios II multi-cycle custom-instruction interface, sitting beside the combinational fp_multiplier in the NN accelerator datapath.
- Iterative restoring mantissa division, round-to-nearest-even, flush-to-zero for denormal inputs and results.

---
 rtl/fp_div_pkg.sv | 34 +++
 rtl/fp_div_mant_core.sv | 63 ++++++
 rtl/fp_divider.sv | 164 ++++++++++++++++
 tb/tb_fp_divider.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the fp_divider block.
package fp_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_ROUND,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        FC_NORMAL,
        FC_ZERO,
        FC_INF,
        FC_NAN
    } fp_class_t;

    localparam int          FP_BIAS    = 127;
    localparam int          FP_EXP_MAX = 255;
    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam logic [31:0] FP_INF     = 32'h7F800000;
    localparam int          Q_BITS     = 26;

    // Denormals classify as zero (flush-to-zero on input).
    function automatic fp_class_t fp_classify(input logic [31:0] x);
        if (x[30:23] == 8'd0)
            return FC_ZERO;
        else if (x[30:23] == 8'hFF)
            return (x[22:0] == 23'd0) ? FC_INF : FC_NAN;
        else
            return FC_NORMAL;
    endfunction

endpackage

// File: rtl/fp_div_mant_core.sv
// Restoring mantissa divider: q = floor(ma * 2^25 / mb), resolving
// ITERS_PER_CYCLE quotient bits per enabled step.
module fp_div_mant_core
    import fp_div_pkg::*;
#(
    parameter int ITERS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              load,
    input  logic              step,
    input  logic [23:0]       ma,
    input  logic [23:0]       mb,
    output logic [Q_BITS-1:0] q,
    output logic              rem_nz
);

    if (ITERS_PER_CYCLE != 1 && ITERS_PER_CYCLE != 2) begin : g_bad_iters
        $error("fp_div_mant_core: ITERS_PER_CYCLE must be 1 or 2");
    end

    // Partial remainder stays below 2*mb, so 25 bits hold it after the shift.
    logic [24:0]       rem_r;
    logic [23:0]       div_r;
    logic [24:0]       r_nxt;
    logic [Q_BITS-1:0] q_nxt;

    always_comb begin
        r_nxt = rem_r;
        q_nxt = q;
        for (int i = 0; i < ITERS_PER_CYCLE; i++) begin
            if (r_nxt >= {1'b0, div_r}) begin
                q_nxt = {q_nxt[Q_BITS-2:0], 1'b1};
                r_nxt = (r_nxt - {1'b0, div_r}) << 1;
            end else begin
                q_nxt = {q_nxt[Q_BITS-2:0], 1'b0};
                r_nxt = r_nxt << 1;
            end
        end
    end

    // After the last step rem_r holds 2*remainder; only its zero-ness matters.
    assign rem_nz = |rem_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r <= '0;
            div_r <= '0;
            q     <= '0;
        end else if (clk_en) begin
            if (load) begin
                rem_r <= {1'b0, ma};
                div_r <= mb;
                q     <= '0;
            end else if (step) begin
                rem_r <= r_nxt;
                q     <= q_nxt;
            end
        end
    end

endmodule

// File: rtl/fp_divider.sv
// Multi-cycle IEEE-754 single-precision divider (dataa / datab), RNE, FTZ.
// Optional FP_DIV_SPECIAL_BYPASS_EN: special operands finish one cycle after start.
module fp_divider
    import fp_div_pkg::*;
#(
    parameter int ITERS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        done,
    output logic [31:0] result
);

    // Handshake: start is honoured only in IDLE with clk_en high, operands
    // sampled on that edge; done pulses for one enabled cycle with result
    // valid alongside it, and result then holds until the next done.

    localparam int                 CALC_CYCLES = Q_BITS / ITERS_PER_CYCLE;
    localparam logic [4:0]         CNT_LOAD    = 5'(CALC_CYCLES - 1);
    localparam logic signed [9:0]  EXP_MAX_S   = 10'(FP_EXP_MAX);
    localparam logic signed [9:0]  BIAS_HI     = 10'(FP_BIAS);
    localparam logic signed [9:0]  BIAS_LO     = 10'(FP_BIAS - 1);

    state_t            state;
    logic [4:0]        cnt;
    logic              sign_r;
    logic signed [9:0] ediff_r;
    logic              spec_r;
    logic [31:0]       spec_val_r;

    fp_class_t         cls_a;
    fp_class_t         cls_b;
    logic              sign_in;
    logic              spec_in;
    logic [31:0]       spec_val_in;
    logic signed [9:0] ediff_in;

    logic [Q_BITS-1:0] q;
    logic              rem_nz;
    logic              accept;

    assign cls_a    = fp_classify(dataa);
    assign cls_b    = fp_classify(datab);
    assign sign_in  = dataa[31] ^ datab[31];
    assign ediff_in = $signed({2'b00, dataa[30:23]}) - $signed({2'b00, datab[30:23]});
    assign accept   = (state == S_IDLE) && start;

    always_comb begin
        spec_in     = (cls_a != FC_NORMAL) || (cls_b != FC_NORMAL);
        spec_val_in = {sign_in, 31'd0};
        if (cls_a == FC_NAN)
            spec_val_in = dataa;
        else if (cls_b == FC_NAN)
            spec_val_in = datab;
        else if ((cls_a == FC_INF && cls_b == FC_INF) || (cls_a == FC_ZERO && cls_b == FC_ZERO))
            spec_val_in = FP_QNAN;
        else if (cls_a == FC_INF || cls_b == FC_ZERO)
            spec_val_in = {sign_in, FP_INF[30:0]};
    end

    fp_div_mant_core #(
        .ITERS_PER_CYCLE(ITERS_PER_CYCLE)
    ) u_core (
        .clk    (clk),
        .rst    (reset),
        .clk_en (clk_en),
        .load   (accept),
        .step   (state == S_CALC),
        .ma     ({1'b1, dataa[22:0]}),
        .mb     ({1'b1, datab[22:0]}),
        .q      (q),
        .rem_nz (rem_nz)
    );

    logic [22:0]       mant;
    logic              g_bit;
    logic              s_bit;
    logic [23:0]       mant_inc;
    logic signed [9:0] exp_pre;
    logic signed [9:0] exp_fin;
    logic [31:0]       rnd_val;

    // Normalise on q[25], round to nearest even, then range-check the exponent.
    always_comb begin
        if (q[25]) begin
            mant    = q[24:2];
            g_bit   = q[1];
            s_bit   = q[0] | rem_nz;
            exp_pre = ediff_r + BIAS_HI;
        end else begin
            mant    = q[23:1];
            g_bit   = q[0];
            s_bit   = rem_nz;
            exp_pre = ediff_r + BIAS_LO;
        end
        mant_inc = {1'b0, mant} + {23'd0, g_bit & (s_bit | mant[0])};
        exp_fin  = exp_pre + $signed({9'd0, mant_inc[23]});
        if (exp_fin >= EXP_MAX_S)
            rnd_val = {sign_r, FP_INF[30:0]};
        else if (exp_fin <= 10'sd0)
            rnd_val = {sign_r, 31'd0};
        else
            rnd_val = {sign_r, exp_fin[7:0], mant_inc[22:0]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sign_r     <= 1'b0;
            ediff_r    <= '0;
            spec_r     <= 1'b0;
            spec_val_r <= '0;
            done       <= 1'b0;
            result     <= '0;
        end else if (clk_en) begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sign_r     <= sign_in;
                        ediff_r    <= ediff_in;
                        spec_r     <= spec_in;
                        spec_val_r <= spec_val_in;
                        cnt        <= CNT_LOAD;
`ifdef FP_DIV_SPECIAL_BYPASS_EN
                        if (spec_in) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            result <= spec_val_in;
                        end else begin
                            state  <= S_CALC;
                        end
`else
                        state <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    if (cnt == 5'd0)
                        state <= S_ROUND;
                    else
                        cnt <= cnt - 5'd1;
                end
                S_ROUND: begin
                    state  <= S_DONE;
                    done   <= 1'b1;
                    result <= spec_r ? spec_val_r : rnd_val;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed cases, random operands against
// an arithmetic reference model, and clk_en / restart / reset control cases.
module tb_fp_divider;

    localparam int ITERS    = 1;
    localparam int LAT_CALC = 26 / ITERS + 2;
    localparam int WINDOW   = 45;
`ifdef FP_DIV_SPECIAL_BYPASS_EN
    localparam int LAT_SPEC = 1;
`else
    localparam int LAT_SPEC = LAT_CALC;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        done;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    fp_divider #(
        .ITERS_PER_CYCLE(ITERS)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .datab  (datab),
        .done   (done),
        .result (result)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $display("FAIL %s: observed=%08h expected=%08h", tag, obs, exp_v);
            $error("%s observed %08h expected %08h", tag, obs, exp_v);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs == exp_v) else begin
            errors++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
            $error("%s observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'd0) || (a[30:23] == 8'hFF) ||
               (b[30:23] == 8'd0) || (b[30:23] == 8'hFF);
    endfunction

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int     ea, eb, e, shift;
        bit     sgn, a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, up;
        longint ma, mb, num, q, rem, m, low, half;
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        sgn    = a[31] ^ b[31];
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        if (a_nan) return a;
        if (b_nan) return b;
        if ((a_inf && b_inf) || (a_zero && b_zero)) return 32'h7FC00000;
        if (a_inf || b_zero) return {sgn, 31'h7F800000};
        if (a_zero || b_inf) return {sgn, 31'd0};
        ma    = 64'h800000 + longint'(a[22:0]);
        mb    = 64'h800000 + longint'(b[22:0]);
        num   = ma * (64'd1 << 25);
        q     = num / mb;
        rem   = num % mb;
        shift = (q >= (64'd1 << 25)) ? 2 : 1;
        m     = q >> shift;
        low   = q - (m << shift);
        half  = 64'd1 << (shift - 1);
        e     = ea - eb + 125 + shift;
        up    = (low > half) || ((low == half) && ((rem != 0) || (m % 2 == 1)));
        if (up) m = m + 1;
        if (m == (64'd1 << 24)) begin
            m = 64'd1 << 23;
            e = e + 1;
        end
        if (e >= 255) return {sgn, 31'h7F800000};
        if (e <= 0) return {sgn, 31'd0};
        return {sgn, 8'(e), 23'(m)};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] specials[7];
        logic [31:0] v;
        specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                     32'h7FC00000, 32'h7F800123, 32'h00000123};
        v = $urandom();
        case ($urandom_range(0, 9))
            0:       v = specials[$urandom_range(0, 6)];
            1:       v[30:23] = 8'($urandom_range(1, 254));
            default: v[30:23] = 8'($urandom_range(110, 145));
        endcase
        return v;
    endfunction

    // ---------------- driver ----------------
    // Issues start in cycle 0 and watches a fixed window; rN = extra start
    // pulses, gate = clk_en-low cycles, rst_at = cycle in which reset rises.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int r1, input int r2, input int r3,
                          input int gate_at, input int gate_len, input int rst_at,
                          output logic [31:0] res, output int lat, output int ndone,
                          output logic rst_done, output logic [31:0] rst_res);
        res      = '0;
        lat      = -1;
        ndone    = 0;
        rst_done = 1'b1;
        rst_res  = 32'hFFFFFFFF;
        @(negedge clk);
        dataa = a;
        datab = b;
        start = 1'b1;
        for (int n = 1; n <= WINDOW; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = n;
                    res = result;
                end
            end
            if (n == rst_at + 1) begin
                rst_done = done;
                rst_res  = result;
            end
            start  = (n == r1) || (n == r2) || (n == r3);
            clk_en = !((gate_len > 0) && (n >= gate_at) && (n < gate_at + gate_len));
            reset  = (n == rst_at);
        end
        start  = 1'b0;
        clk_en = 1'b1;
        reset  = 1'b0;
    endtask

    task automatic run_scored(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_v);
        logic [31:0] res, rr;
        int          lat, nd;
        logic        rd;
        exp_q.push_back(exp_v);
        run_op(a, b, -1, -1, -1, 0, 0, -1, res, lat, nd, rd, rr);
        check32({tag, "_result"}, res, exp_q.pop_front());
        check_int({tag, "_latency"}, lat, is_special(a, b) ? LAT_SPEC : LAT_CALC);
        check_int({tag, "_done_count"}, nd, 1);
    endtask

    // ---------------- directed table ----------------
    logic [31:0] dir_a[12] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000,
                               32'h00000000, 32'hFF800000, 32'h7FC00001, 32'h3F800000,
                               32'h7F000000, 32'h00800000, 32'h3F800000, 32'h7F800000};
    logic [31:0] dir_b[12] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h00000000,
                               32'h00000000, 32'h7F800000, 32'h3F800000, 32'hFF800000,
                               32'h00800000, 32'h40000000, 32'h7FC00005, 32'hBF800000};
    logic [31:0] dir_q[12] = '{32'h40400000, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'h7F800000,
                               32'h7FC00000, 32'h7FC00000, 32'h7FC00001, 32'h80000000,
                               32'h7F800000, 32'h00000000, 32'h7FC00005, 32'hFF800000};

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] a, b, res, rr;
        int          lat, nd;
        logic        rd;

        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        dataa  = '0;
        datab  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_int("reset_done", int'(done), 0);
        check32("reset_result", result, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            run_scored($sformatf("dir%0d", i), dir_a[i], dir_b[i], dir_q[i]);

        for (int i = 0; i < 40; i++) begin
            a = rand_operand();
            b = rand_operand();
            run_scored($sformatf("rnd%0d_%08h_%08h", i, a, b), a, b, ref_div(a, b));
        end

        // Extra starts during CALC, ROUND and the DONE cycle are ignored.
        run_op(32'h40C00000, 32'h40000000, 5, LAT_CALC - 1, LAT_CALC, 0, 0, -1,
               res, lat, nd, rd, rr);
        check32("restart_result", res, 32'h40400000);
        check_int("restart_latency", lat, LAT_CALC);
        check_int("restart_done_count", nd, 1);

        // clk_en low for 10 cycles mid-CALC stretches latency by 10.
        run_op(32'h3F800000, 32'h40400000, -1, -1, -1, 4, 10, -1, res, lat, nd, rd, rr);
        check32("gate_result", res, 32'h3EAAAAAB);
        check_int("gate_latency", lat, LAT_CALC + 10);
        check_int("gate_done_count", nd, 1);

        // Reset at cycle 12 aborts the operation.
        run_op(32'h40C00000, 32'h40000000, -1, -1, -1, 0, 0, 12, res, lat, nd, rd, rr);
        check_int("abort_reset_done", int'(rd), 0);
        check32("abort_reset_result", rr, 32'h0);
        check_int("abort_done_count", nd, 0);

        run_op(32'h3F800000, 32'h40400000, -1, -1, -1, 0, 0, -1, res, lat, nd, rd, rr);
        check32("post_reset_result", res, 32'h3EAAAAAB);
        check_int("post_reset_latency", lat, LAT_CALC);
        check_int("post_reset_done_count", nd, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
